sram22_arb_ctrl: RTL and testbench
==================================

Name: sram22_arb_ctrl

Overview:
- Front-end controller for one single-port SRAM22 macro (256 words x 32 bits, 4 byte-lane write mask, 1-cycle synchronous read, dout undefined on write cycles).
- After reset, sequences a zero-fill of the whole array.
- Then shares the macro between two requesters (A, B) with round-robin arbitration, and routes read data back to the port that issued the read.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- WMASK_WIDTH, 4, byte-lane mask width (DATA_WIDTH/8).
- INIT_ON_RESET, 1, 1 = zero-fill after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once zero-fill is complete.
- a_req_valid, b_req_valid  in  1  request present.
- a_req_ready, b_req_ready  out  1  request accepted this cycle.
- a_req_we, b_req_we  in  1  1 = write, 0 = read.
- a_req_wmask, b_req_wmask  in  WMASK_WIDTH  byte enables for writes.
- a_req_addr, b_req_addr  in  ADDR_WIDTH  word address.
- a_req_wdata, b_req_wdata  in  DATA_WIDTH  write data.
- a_rsp_valid, b_rsp_valid  out  1  read data valid.
- a_rsp_rdata, b_rsp_rdata  out  DATA_WIDTH  read data.
- sram_we  out  1  to macro we.
- sram_wmask  out  WMASK_WIDTH  to macro wmask.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.

Behaviour:
- Reset (async, rst_n low):
  - State = INIT if INIT_ON_RESET, else RUN.
  - init_cnt=0, rr_ptr=A, rd_pend_a=rd_pend_b=0.
  - init_done=0 (1 if INIT_ON_RESET=0); a/b_rsp_valid=0; req_ready=0.
- INIT state:
  - Drives sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=init_cnt.
  - init_cnt increments each cycle.
  - After the write at RAM_DEPTH-1 (exactly RAM_DEPTH cycles), move to RUN; init_done=1 from the next cycle.
  - Both req_ready held 0 throughout.
- RUN state, arbitration (combinational, same cycle):
  - Only one valid: that port is granted.
  - Both valid: the port named by rr_ptr is granted.
  - On any grant, rr_ptr <= the non-granted port, so back-to-back contention alternates A,B,A,B.
  - x_req_ready = grant_x. At most one ready high per cycle.
- Macro drive:
  - Granted port: sram_we/wmask/addr/din = that port's request fields.
  - No grant: sram_we=0, wmask=0, addr=0, din=0 (idle read; result discarded).
- Reads:
  - A granted read sets rd_pend_x for one cycle.
  - Next cycle: x_rsp_valid=1 and x_rsp_rdata=sram_dout. Latency is exactly 1 cycle from the accept edge.
  - No response backpressure; a requester must take the response when valid.
  - x_rsp_rdata = sram_dout when valid, 0 otherwise.
- Writes:
  - No response; the write is performed at the accept edge.
  - wmask=0 is accepted as a no-op.
  - A read of the same address on the next cycle returns the written bytes merged with the old unmasked bytes.
- Throughput: one access per cycle total; zero bubbles between grants.
- Reset mid-operation: an in-flight read response is dropped (rsp_valid forced 0); INIT restarts from address 0.
- Requests arriving during INIT are held off (ready=0), not dropped; the requester keeps valid asserted.

Optional Feature:
- Macro: SRAM22_ARB_PERF_EN.
- Defined: adds ports perf_clr (in, 1) and perf_grant_a, perf_grant_b, perf_stall (out, 16 each).
  - perf_grant_x counts grants to port x.
  - perf_stall counts cycles in RUN where a valid request was not granted: +1 per losing port, so +1 max per cycle with two ports.
  - All counters saturate at 16'hFFFF; synchronous clear on perf_clr; reset to 0.
  - perf_clr and an increment in the same cycle: clear wins.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with INIT_ON_RESET=1 -> sram_we=1 with addr 0..255 over 256 cycles; init_done rises the following cycle; a_req_ready=0 throughout even with a_req_valid=1.
- After init, A reads addr 0x10 -> a_rsp_valid=1 one cycle later with rdata=0x00000000.
- A writes addr 0x20, data 0xDEADBEEF, wmask 4'b0101; next cycle A reads 0x20 -> rdata=0x00AD00EF.
- A and B both valid with reads for 6 cycles -> grants A,B,A,B,A,B; each response appears only on the issuing port, 1 cycle after its grant.
- B read granted, then rst_n pulsed low in the response cycle -> b_rsp_valid=0 immediately; INIT restarts at addr 0.
- With SRAM22_ARB_PERF_EN: 4 contended cycles -> perf_grant_a=2, perf_grant_b=2, perf_stall=4; perf_clr -> all 0 next cycle.

Source files
------------

// File: rtl/sram22_arb_ctrl.sv
// rtl/sram22_arb_ctrl.sv - SRAM22 front-end: zero-fill after reset, then two-port round-robin access
//
// Purpose:
//   Owns one single-port SRAM22 macro (1-cycle synchronous read). After reset the
//   whole array is zero-filled (when INIT_ON_RESET=1). After that, requesters A and B
//   share the macro with round-robin arbitration. Read data is returned one cycle
//   after the accept edge, on the port that issued the read.
//
// Optional feature macro: SRAM22_ARB_PERF_EN (grant/stall performance counters).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   init_done                  high once the zero-fill has completed
//   x_req_valid/ready          request handshake (x = a, b)
//   x_req_we/wmask/addr/wdata  request fields (we=1 write, we=0 read)
//   x_rsp_valid/rdata          read response, one cycle after accept
//   sram_we/wmask/addr/din     macro drive
//   sram_dout                  macro read data
//   perf_clr                   (perf only) synchronous counter clear
//   perf_grant_a/b, perf_stall (perf only) saturating 16-bit counters

module sram22_arb_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int WMASK_WIDTH   = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   a_req_valid,
  output logic                   a_req_ready,
  input  logic                   a_req_we,
  input  logic [WMASK_WIDTH-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0]  a_req_addr,
  input  logic [DATA_WIDTH-1:0]  a_req_wdata,
  output logic                   a_rsp_valid,
  output logic [DATA_WIDTH-1:0]  a_rsp_rdata,
  input  logic                   b_req_valid,
  output logic                   b_req_ready,
  input  logic                   b_req_we,
  input  logic [WMASK_WIDTH-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0]  b_req_addr,
  input  logic [DATA_WIDTH-1:0]  b_req_wdata,
  output logic                   b_rsp_valid,
  output logic [DATA_WIDTH-1:0]  b_rsp_rdata,
`ifdef SRAM22_ARB_PERF_EN
  input  logic                   perf_clr,
  output logic [15:0]            perf_grant_a,
  output logic [15:0]            perf_grant_b,
  output logic [15:0]            perf_stall,
`endif
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Round-robin pointer encoding: 0 = A has priority, 1 = B has priority.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  localparam logic [0:0] ST_RESET   = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic       DONE_RESET = (INIT_ON_RESET == 0);

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  r_rr_ptr;
  logic                  r_rd_pend_a;
  logic                  r_rd_pend_b;

  logic w_run;
  logic w_grant_a;
  logic w_grant_b;
  logic w_init_last;

  assign w_run       = (r_state == ST_RUN);
  assign w_init_last = (r_init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1));

  // A wins when alone or when it holds priority; B wins whenever A does not.
  assign w_grant_a = w_run & a_req_valid & (~b_req_valid | (r_rr_ptr == RR_A));
  assign w_grant_b = w_run & b_req_valid & ~w_grant_a;

  assign a_req_ready = w_grant_a;
  assign b_req_ready = w_grant_b;
  assign init_done   = r_init_done;

  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (!w_run) begin
      sram_we    = 1'b1;
      sram_wmask = '1;
      sram_addr  = r_init_cnt;
    end else if (w_grant_a) begin
      sram_we    = a_req_we;
      sram_wmask = a_req_wmask;
      sram_addr  = a_req_addr;
      sram_din   = a_req_wdata;
    end else if (w_grant_b) begin
      sram_we    = b_req_we;
      sram_wmask = b_req_wmask;
      sram_addr  = b_req_addr;
      sram_din   = b_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_init_cnt  <= '0;
      r_init_done <= DONE_RESET;
      r_rr_ptr    <= RR_A;
      r_rd_pend_a <= 1'b0;
      r_rd_pend_b <= 1'b0;
    end else begin
      if (!w_run) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (w_init_last) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end
      if (w_grant_a) begin
        r_rr_ptr <= RR_B;
      end else if (w_grant_b) begin
        r_rr_ptr <= RR_A;
      end
      r_rd_pend_a <= w_grant_a & ~a_req_we;
      r_rd_pend_b <= w_grant_b & ~b_req_we;
    end
  end

  // Macro output is only meaningful in the cycle after a read accept.
  assign a_rsp_valid = r_rd_pend_a;
  assign b_rsp_valid = r_rd_pend_b;
  assign a_rsp_rdata = r_rd_pend_a ? sram_dout : '0;
  assign b_rsp_rdata = r_rd_pend_b ? sram_dout : '0;

`ifdef SRAM22_ARB_PERF_EN
  logic [15:0] r_perf_grant_a;
  logic [15:0] r_perf_grant_b;
  logic [15:0] r_perf_stall;
  logic        w_stall;

  // Only one port can lose in a cycle, so this is a single increment.
  assign w_stall = w_run & ((a_req_valid & ~w_grant_a) | (b_req_valid & ~w_grant_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant_a <= '0;
      r_perf_grant_b <= '0;
      r_perf_stall   <= '0;
    end else if (perf_clr) begin
      r_perf_grant_a <= '0;
      r_perf_grant_b <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_grant_a && (r_perf_grant_a != 16'hFFFF)) r_perf_grant_a <= r_perf_grant_a + 16'd1;
      if (w_grant_b && (r_perf_grant_b != 16'hFFFF)) r_perf_grant_b <= r_perf_grant_b + 16'd1;
      if (w_stall && (r_perf_stall != 16'hFFFF))     r_perf_stall   <= r_perf_stall + 16'd1;
    end
  end

  assign perf_grant_a = r_perf_grant_a;
  assign perf_grant_b = r_perf_grant_b;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_sram22_arb_ctrl.sv
// tb/tb_sram22_arb_ctrl.sv - self-checking bench for sram22_arb_ctrl

module tb_sram22_arb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [3:0]  a_req_wmask;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [3:0]  b_req_wmask;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_rdata;
  logic        sram_we;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
`ifdef SRAM22_ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] perf_grant_a, perf_grant_b, perf_stall;
`endif

  sram22_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
`ifdef SRAM22_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_grant_a(perf_grant_a), .perf_grant_b(perf_grant_b),
    .perf_stall(perf_stall),
`endif
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: starts with garbage so the zero-fill is observable.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = $urandom;
  always @(posedge clk) begin
    if (sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  // Reference memory contents as seen by requesters (zero after fill).
  logic [31:0] m_mem [256];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        av, awe;
    logic [7:0]  aaddr;
    logic [31:0] ad;
    logic [3:0]  am;
    logic        bv, bwe;
    logic [7:0]  baddr;
    logic [31:0] bd;
    logic [3:0]  bm;
    logic        ega, egb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic av, logic awe, logic [7:0] aaddr, logic [31:0] ad, logic [3:0] am,
                              logic bv, logic bwe, logic [7:0] baddr, logic [31:0] bd, logic [3:0] bm,
                              logic ega, logic egb);
    vec_t v;
    v.av = av; v.awe = awe; v.aaddr = aaddr; v.ad = ad; v.am = am;
    v.bv = bv; v.bwe = bwe; v.baddr = baddr; v.bd = bd; v.bm = bm;
    v.ega = ega; v.egb = egb;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(vec_t v);
    a_req_valid = v.av; a_req_we = v.awe; a_req_addr = v.aaddr; a_req_wdata = v.ad; a_req_wmask = v.am;
    b_req_valid = v.bv; b_req_we = v.bwe; b_req_addr = v.baddr; b_req_wdata = v.bd; b_req_wmask = v.bm;
  endtask

  task automatic check_rsp();
    if (qa.size() > 0) begin
      chk("a_rsp_valid", a_rsp_valid, 1);
      chk("a_rsp_rdata", a_rsp_rdata, qa.pop_front());
    end else begin
      chk("a_rsp_idle_valid", a_rsp_valid, 0);
      chk("a_rsp_idle_rdata", a_rsp_rdata, 0);
    end
    if (qb.size() > 0) begin
      chk("b_rsp_valid", b_rsp_valid, 1);
      chk("b_rsp_rdata", b_rsp_rdata, qb.pop_front());
    end else begin
      chk("b_rsp_idle_valid", b_rsp_valid, 0);
      chk("b_rsp_idle_rdata", b_rsp_rdata, 0);
    end
  endtask

  // Checks the grant against the expectation and pushes predicted read data.
  task automatic issue(logic ega, logic egb);
    chk("a_req_ready", a_req_ready, ega);
    chk("b_req_ready", b_req_ready, egb);
    if (ega) begin
      chk("sram_we_a", sram_we, a_req_we);
      chk("sram_addr_a", sram_addr, a_req_addr);
      if (a_req_we) m_mem[a_req_addr] = merge(m_mem[a_req_addr], a_req_wdata, a_req_wmask);
      else          qa.push_back(m_mem[a_req_addr]);
    end else if (egb) begin
      chk("sram_we_b", sram_we, b_req_we);
      chk("sram_addr_b", sram_addr, b_req_addr);
      if (b_req_we) m_mem[b_req_addr] = merge(m_mem[b_req_addr], b_req_wdata, b_req_wmask);
      else          qb.push_back(m_mem[b_req_addr]);
    end else begin
      chk("sram_we_idle", sram_we, 0);
    end
  endtask

  task automatic run_vec(vec_t v);
    apply(v);
    @(negedge clk);
    check_rsp();
    issue(v.ega, v.egb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    vec_t cont;
    int n;

    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

    //              av awe aaddr  adata         am       bv bwe baddr  bdata         bm       ga gb
    vecs[0]  = mk(1, 1, 8'h20, 32'hDEADBEEF, 4'b0101, 0, 0, 8'h00, 32'h0,        4'b0000, 1, 0);
    vecs[1]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 0, 0, 8'h00, 32'h0,        4'b0000, 1, 0);
    vecs[2]  = mk(0, 0, 8'h00, 32'h0,        4'b0000, 1, 1, 8'h21, 32'h12345678, 4'b1111, 0, 1);
    vecs[3]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 1, 0);
    vecs[4]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 0, 1);
    vecs[5]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 1, 0);
    vecs[6]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 0, 1);
    vecs[7]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 1, 0);
    vecs[8]  = mk(1, 0, 8'h20, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 0, 1);
    vecs[9]  = mk(0, 0, 8'h00, 32'h0,        4'b0000, 1, 1, 8'h21, 32'hFFFFFFFF, 4'b0000, 0, 1);
    vecs[10] = mk(0, 0, 8'h00, 32'h0,        4'b0000, 1, 0, 8'h21, 32'h0,        4'b0000, 0, 1);
    vecs[11] = mk(0, 0, 8'h00, 32'h0,        4'b0000, 0, 0, 8'h00, 32'h0,        4'b0000, 0, 0);
    vecs[12] = mk(1, 1, 8'h30, 32'hCAFEF00D, 4'b1000, 1, 1, 8'h30, 32'h11223344, 4'b0001, 1, 0);
    vecs[13] = mk(0, 0, 8'h00, 32'h0,        4'b0000, 1, 1, 8'h30, 32'h11223344, 4'b0001, 0, 1);
    vecs[14] = mk(1, 0, 8'h30, 32'h0,        4'b0000, 0, 0, 8'h00, 32'h0,        4'b0000, 1, 0);
    idle = vecs[11];

`ifdef SRAM22_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    // A read of 0x10 is presented during the fill and must be held off.
    apply(idle);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h10;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      chk("init_we", sram_we, 1);
      chk("init_addr", sram_addr, i);
      chk("init_wmask", sram_wmask, 4'hF);
      chk("init_din", sram_din, 0);
      chk("init_a_ready", a_req_ready, 0);
      chk("init_done_low", init_done, 0);
      @(negedge clk);
    end
    chk("init_done_high", init_done, 1);
    check_rsp();
    issue(1'b1, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // B read accepted, then reset lands in its response cycle.
    cont = mk(0, 0, 8'h00, 32'h0, 4'b0000, 1, 0, 8'h21, 32'h0, 4'b0000, 0, 1);
    apply(cont);
    @(negedge clk);
    check_rsp();
    issue(1'b0, 1'b1);
    @(posedge clk);
    #1;
    apply(idle);
    chk("pre_rst_b_rsp_valid", b_rsp_valid, 1);
    chk("pre_rst_b_rsp_rdata", b_rsp_rdata, qb.pop_front());
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b_rsp_valid", b_rsp_valid, 0);
    chk("mid_rst_b_rsp_rdata", b_rsp_rdata, 0);
    chk("mid_rst_init_done", init_done, 0);
    qa.delete();
    qb.delete();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reinit_we", sram_we, 1);
    chk("reinit_addr", sram_addr, 0);
    n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reinit_cycles", n, 256);

    // Earlier writes must be gone after the second fill.
    run_vec(mk(1, 0, 8'h20, 32'h0, 4'b0000, 0, 0, 8'h00, 32'h0, 4'b0000, 1, 0));
    run_vec(idle);

`ifdef SRAM22_ARB_PERF_EN
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    chk("perf_clr_ga", perf_grant_a, 0);
    chk("perf_clr_gb", perf_grant_b, 0);
    chk("perf_clr_st", perf_stall, 0);
    cont = mk(1, 0, 8'h20, 32'h0, 4'b0000, 1, 0, 8'h21, 32'h0, 4'b0000, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cont.ega = (i % 2) == 1;
      cont.egb = (i % 2) == 0;
      run_vec(cont);
    end
    run_vec(idle);
    chk("perf_grant_a", perf_grant_a, 2);
    chk("perf_grant_b", perf_grant_b, 2);
    chk("perf_stall", perf_stall, 4);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    chk("perf_clr2_ga", perf_grant_a, 0);
    chk("perf_clr2_gb", perf_grant_b, 0);
    chk("perf_clr2_st", perf_stall, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
